// File: rtl/grayscale_pipe.sv
// Two-stage pipelined RGB-to-grayscale converter between a FWFT input FIFO and an
// output FIFO, with selectable reduction and a per-frame write counter.
module grayscale_pipe #(
  parameter int CHAN_WIDTH   = 8,
  parameter int DWIDTH_IN    = 3 * CHAN_WIDTH,
  parameter int DWIDTH_OUT   = CHAN_WIDTH,
  parameter int FRAME_PIXELS = 720 * 540
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            mode,
  output logic                  fifo_in_rd_en,
  input  logic [DWIDTH_IN-1:0]  fifo_in_dout,
  input  logic                  fifo_in_empty,
  output logic                  fifo_out_wr_en,
  output logic [DWIDTH_OUT-1:0] fifo_out_din,
  input  logic                  fifo_out_full,
  output logic                  frame_done
);

  localparam int C     = CHAN_WIDTH;
  localparam int PW    = CHAN_WIDTH + 8;
  localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

  typedef enum logic [1:0] {
    MODE_AVG   = 2'd0,
    MODE_LUMA  = 2'd1,
    MODE_GREEN = 2'd2,
    MODE_MAX   = 2'd3
  } mode_e;

  // Handshake: a stage accepts when the stage after it is empty or draining.
  //   advance        = !s2_valid || !fifo_out_full
  //   fifo_out_wr_en = s2_valid && !fifo_out_full
  //   fifo_in_rd_en  = !fifo_in_empty && (!s1_valid || advance)
  logic             advance;
  logic             s1_valid_q, s1_valid_d;
  mode_e            s1_mode_q, s1_mode_d;
  logic [PW-1:0]    s1_part_q, s1_part_d;
  logic [C-1:0]     s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [C-1:0]     dout_q, dout_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             cnt_last;

  logic [C-1:0]     in_r, in_g, in_b;
  logic [C-1:0]     s2_result;
  logic [C-1:0]     s1_part_chan;

  assign in_r = fifo_in_dout[3*C-1:2*C];
  assign in_g = fifo_in_dout[2*C-1:C];
  assign in_b = fifo_in_dout[C-1:0];

  assign advance        = !s2_valid_q || !fifo_out_full;
  assign fifo_out_wr_en = !reset && s2_valid_q && !fifo_out_full;
  assign fifo_in_rd_en  = !reset && !fifo_in_empty && (!s1_valid_q || advance);

  assign cnt_last     = (pix_cnt_q == CNT_W'(FRAME_PIXELS - 1));
  assign frame_done   = fifo_out_wr_en && cnt_last;
  assign fifo_out_din = dout_q;

  // Stage 1: partial reduction of the popped pixel, mode captured alongside it.
  always_comb begin
    s1_valid_d = fifo_in_rd_en || (s1_valid_q && !advance);
    s1_mode_d  = s1_mode_q;
    s1_part_d  = s1_part_q;
    s1_b_d     = s1_b_q;
    if (fifo_in_rd_en) begin
      s1_mode_d = mode_e'(mode);
      s1_b_d    = in_b;
      case (mode_e'(mode))
        MODE_AVG:   s1_part_d = PW'(in_r) + PW'(in_g) + PW'(in_b);
        MODE_LUMA:  s1_part_d = PW'(in_r) * PW'(77) + PW'(in_g) * PW'(150)
                              + PW'(in_b) * PW'(29);
        MODE_GREEN: s1_part_d = PW'(in_g);
        MODE_MAX:   s1_part_d = PW'((in_r > in_g) ? in_r : in_g);
        default:    s1_part_d = '0;
      endcase
    end
  end

  // Stage 2: finish the reduction. Weights sum to 256, so the rounded luma fits C bits.
  always_comb begin
    s2_result    = '0;
    s1_part_chan = C'(s1_part_q);
    case (s1_mode_q)
      MODE_AVG:   s2_result = C'(s1_part_q / PW'(3));
      MODE_LUMA:  s2_result = C'((s1_part_q + PW'(128)) >> 8);
      MODE_GREEN: s2_result = s1_part_chan;
      MODE_MAX:   s2_result = (s1_part_chan > s1_b_q) ? s1_part_chan : s1_b_q;
      default:    s2_result = '0;
    endcase
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    dout_d     = dout_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        dout_d = s2_result;
      end
    end
  end

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (fifo_out_wr_en) begin
      pix_cnt_d = cnt_last ? '0 : pix_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_AVG;
      s1_part_q  <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      dout_q     <= '0;
      pix_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_part_q  <= s1_part_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      dout_q     <= dout_d;
      pix_cnt_q  <= pix_cnt_d;
    end
  end

endmodule

// File: tb/tb_grayscale_pipe.sv
// Directed bench for grayscale_pipe: FIFO-side stimulus, expected-value queue,
// per-cycle handshake and frame checks, one summary line.
module tb_grayscale_pipe;

  localparam int FP = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        fifo_in_rd_en;
  logic [23:0] fifo_in_dout;
  logic        fifo_in_empty;
  logic        fifo_out_wr_en;
  logic [7:0]  fifo_out_din;
  logic        fifo_out_full;
  logic        frame_done;

  grayscale_pipe #(.CHAN_WIDTH(8), .FRAME_PIXELS(FP)) dut (
    .clock          (clock),
    .reset          (reset),
    .mode           (mode),
    .fifo_in_rd_en  (fifo_in_rd_en),
    .fifo_in_dout   (fifo_in_dout),
    .fifo_in_empty  (fifo_in_empty),
    .fifo_out_wr_en (fifo_out_wr_en),
    .fifo_out_din   (fifo_out_din),
    .fifo_out_full  (fifo_out_full),
    .frame_done     (frame_done)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [23:0] pix;
    logic [1:0]  mode;
    logic [7:0]  exp;
  } item_t;

  item_t      in_q[$];
  logic [7:0] exp_q[$];
  int         popc_q[$];
  int         fd_idx_q[$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int cnt_m = 0;
  int wr_since_rst = 0;
  int wr_total = 0;
  logic force_empty = 1'b0;
  bit exact_lat = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_gray(input logic [23:0] p, input logic [1:0] m);
    int r, g, b, v;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    case (m)
      2'd0: v = (r + g + b) / 3;
      2'd1: v = (77 * r + 150 * g + 29 * b + 128) / 256;
      2'd2: v = g;
      default: begin
        v = r;
        if (g > v) v = g;
        if (b > v) v = b;
      end
    endcase
    return 8'(v);
  endfunction

  // driver tasks
  task automatic push(input logic [23:0] p, input logic [1:0] m, input logic [7:0] e);
    item_t it;
    it.pix = p;
    it.mode = m;
    it.exp = e;
    in_q.push_back(it);
  endtask

  task automatic drive_inputs();
    if (in_q.size() > 0) begin
      fifo_in_dout = in_q[0].pix;
      mode = in_q[0].mode;
    end else begin
      fifo_in_dout = 24'h0;
      mode = 2'(cycle);
    end
    fifo_in_empty = force_empty || (in_q.size() == 0);
  endtask

  // scoreboard: runs at the falling edge, between input changes and the active edge
  task automatic monitor();
    item_t it;
    int lat;
    if (reset) begin
      check("reset_rd_en", {31'd0, fifo_in_rd_en}, 0);
      check("reset_wr_en", {31'd0, fifo_out_wr_en}, 0);
      check("reset_frame_done", {31'd0, frame_done}, 0);
      exp_q.delete();
      popc_q.delete();
      fd_idx_q.delete();
      cnt_m = 0;
      wr_since_rst = 0;
    end else begin
      if (fifo_out_wr_en) begin
        check("wr_while_full", {31'd0, fifo_out_full}, 0);
        wr_total++;
        wr_since_rst++;
        if (exp_q.size() == 0) begin
          check("spurious_write", 1, 0);
        end else begin
          check("data", {24'd0, fifo_out_din}, {24'd0, exp_q.pop_front()});
        end
        check("frame_done_on_write", {31'd0, frame_done}, (cnt_m == FP - 1) ? 1 : 0);
        cnt_m = (cnt_m == FP - 1) ? 0 : cnt_m + 1;
        if (frame_done) fd_idx_q.push_back(wr_since_rst);
        if (popc_q.size() > 0) begin
          lat = cycle - popc_q.pop_front();
          if (exact_lat) check("latency_exact", lat, 2);
          else check("latency_min", (lat >= 2) ? 1 : 0, 1);
        end
      end else begin
        check("frame_done_idle", {31'd0, frame_done}, 0);
      end
      if (fifo_in_rd_en) begin
        check("rd_while_empty", {31'd0, fifo_in_empty}, 0);
        if (in_q.size() > 0) begin
          it = in_q.pop_front();
          exp_q.push_back(it.exp);
          popc_q.push_back(cycle);
        end
      end
    end
  endtask

  task automatic step();
    drive_inputs();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    cycle++;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n;
    n = 0;
    force_empty = 1'b0;
    fifo_out_full = 1'b0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_timeout", in_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    int w0;
    int n;
    logic [23:0] p;
    logic [1:0]  m;

    reset = 1'b1;
    fifo_out_full = 1'b0;
    mode = 2'd0;
    fifo_in_dout = 24'h0;
    fifo_in_empty = 1'b1;

    // 1: average, pushed before release so rd_en is tested against a non-empty FIFO
    push(24'hFFFFFE, 2'd0, 8'hFE);
    push(24'h000000, 2'd0, 8'h00);
    push(24'h010101, 2'd0, 8'h01);
    step();
    step();
    check("reset_din", {24'd0, fifo_out_din}, 0);
    check("reset_wr_after", {31'd0, fifo_out_wr_en}, 0);
    reset = 1'b0;
    exact_lat = 1'b1;
    w0 = wr_total;
    run_until_idle(50);
    check("avg_writes", wr_total - w0, 3);

    // avg boundaries: largest sum and remainders
    push(24'hFFFFFF, 2'd0, 8'hFF);
    push(24'h000002, 2'd0, 8'h00);
    push(24'h000003, 2'd0, 8'h01);
    push(24'hFEFFFF, 2'd0, 8'hFE);
    run_until_idle(50);

    // 2: luma
    push(24'hFF0000, 2'd1, 8'd77);
    push(24'h00FF00, 2'd1, 8'd149);
    push(24'h0000FF, 2'd1, 8'd29);
    push(24'hFFFFFF, 2'd1, 8'd255);
    run_until_idle(50);

    // 3: green / max, then mode changing every pixel
    push(24'h12AB34, 2'd2, 8'hAB);
    push(24'h3C1FC8, 2'd3, 8'hC8);
    push(24'h3C1FC8, 2'd0, 8'h61);
    push(24'h3C1FC8, 2'd1, 8'h3B);
    push(24'h12AB34, 2'd2, 8'hAB);
    push(24'h12AB34, 2'd3, 8'hAB);
    push(24'h12AB34, 2'd0, 8'h50);
    push(24'h12AB34, 2'd1, 8'h70);
    push(24'h3C1FC8, 2'd3, 8'hC8);
    push(24'h3C1FC8, 2'd2, 8'h1F);
    run_until_idle(50);
    exact_lat = 1'b0;

    // 4: random pixels under random empty/full
    for (int i = 0; i < 100; i++) begin
      p = 24'($urandom_range(0, 24'hFFFFFF));
      m = 2'($urandom_range(0, 3));
      push(p, m, ref_gray(p, m));
    end
    w0 = wr_total;
    n = 0;
    while ((wr_total - w0) < 100 && n < 3000) begin
      force_empty = ($urandom_range(0, 2) == 0);
      fifo_out_full = ($urandom_range(0, 2) == 0);
      step();
      n++;
    end
    force_empty = 1'b0;
    fifo_out_full = 1'b0;
    check("bp_writes", wr_total - w0, 100);
    check("bp_leftover", exp_q.size() + in_q.size(), 0);
    step();
    step();
    check("bp_no_extra", wr_total - w0, 100);

    // 6: reset with two pixels held in a stalled pipeline
    fifo_out_full = 1'b1;
    push(24'h102030, 2'd0, 8'h20);
    push(24'h405060, 2'd0, 8'h50);
    push(24'h0A0B0C, 2'd2, 8'h0B);
    step();
    step();
    check("inflight", exp_q.size(), 2);
    check("stall_rd_en", {31'd0, fifo_in_rd_en}, 0);
    check("stall_wr_en", {31'd0, fifo_out_wr_en}, 0);
    reset = 1'b1;
    fifo_out_full = 1'b0;
    step();
    reset = 1'b0;
    w0 = wr_total;
    run_until_idle(20);
    check("after_reset_writes", wr_total - w0, 1);
    for (int i = 0; i < 15; i++) begin
      p = 24'($urandom_range(0, 24'hFFFFFF));
      push(p, 2'd3, ref_gray(p, 2'd3));
    end
    run_until_idle(100);
    check("restart_fd_count", fd_idx_q.size(), 1);
    check("restart_fd_index", (fd_idx_q.size() > 0) ? fd_idx_q[0] : -1, 16);

    // 5: frame pulses over 40 pixels from a clean reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      p = 24'($urandom_range(0, 24'hFFFFFF));
      push(p, 2'd2, p[15:8]);
    end
    run_until_idle(200);
    check("frame_fd_count", fd_idx_q.size(), 2);
    check("frame_fd_first", (fd_idx_q.size() > 0) ? fd_idx_q[0] : -1, 16);
    check("frame_fd_second", (fd_idx_q.size() > 1) ? fd_idx_q[1] : -1, 32);
    check("frame_writes", wr_since_rst, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
